edge_param_div: RTL and testbench

Sub-pixel edge parameter stage that sits directly downstream of the 3-column window summation stage. It consumes the three column sums (SL, SM, SR), the two side intensities of the edge, and the 4-bit direction code. It then computes the edge offset `a` and slope `b` in signed fixed point. Both are computed with a pair of shared-schedule serial restoring dividers driven by a small FSM. Results feed the sub-pixel coordinate assembly stage.

---
 rtl/edge_param_div.sv | 173 +++++++++++++++++
 tb/tb_edge_param_div.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/edge_param_div.sv
// rtl/edge_param_div.sv - sub-pixel edge offset/slope stage using two shared-schedule serial dividers
module edge_param_div #(
  parameter int FRAC = 8,
  parameter int OW   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           state,
  input  logic [10:0]          sl,
  input  logic [10:0]          sm,
  input  logic [10:0]          sr,
  input  logic [7:0]           int_a,
  input  logic [7:0]           int_b,
  output logic                 out_valid,
  output logic signed [OW-1:0] off_a,
  output logic signed [OW-1:0] slope_b,
  output logic                 edge_ok,
  output logic                 vert
);

  localparam int DW = 12 + FRAC;
  localparam int CW = $clog2(DW);
  localparam int RW = 10;
  localparam logic [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} fsm_t;

  fsm_t fsm, fsm_nx;

  logic [3:0]    st_r;
  logic [10:0]   sl_r, sm_r, sr_r;
  logic [7:0]    ia_r, ib_r;
  logic [8:0]    den_mag;
  logic [DW-1:0] dvd_a, dvd_b, q_a, q_b;
  logic [RW-1:0] rem_a, rem_b;
  logic          sgn_a, sgn_b;
  logic [CW-1:0] cnt;

  logic signed [13:0] ia_s, ib_s, den_s, an_s, bn_s;
  logic [13:0]        den_abs, an_abs, bn_abs;
  logic               neg_dir, vert_dir, last;
  logic [RW:0]        rs_a, rs_b, den_ext;
  logic               ge_a, ge_b;
  logic [DW-1:0]      q_a_nx, q_b_nx;

  function automatic logic signed [OW-1:0] sat(input logic [DW-1:0] q, input logic neg);
    logic [OW-1:0] m;
    m = (q > DW'(MAXV)) ? MAXV : OW'(q);
    return neg ? -m : m;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm <= IDLE;
    else      fsm <= fsm_nx;
  end

  always_comb begin
    fsm_nx = fsm;
    case (fsm)
      IDLE:    if (in_valid) fsm_nx = PREP;
      PREP:    fsm_nx = DIV;
      DIV:     if (cnt == '0) fsm_nx = DONE;
      DONE:    fsm_nx = IDLE;
      default: fsm_nx = IDLE;
    endcase
  end

  assign in_ready = (fsm == IDLE);

  // Non-one-hot codes fall through to the 0010 behaviour: no negation, horizontal window.
  assign neg_dir  = (st_r == 4'b0001) || (st_r == 4'b0100);
  assign vert_dir = (st_r == 4'b0100) || (st_r == 4'b1000);

  always_comb begin
    ia_s    = $signed({6'd0, ia_r});
    ib_s    = $signed({6'd0, ib_r});
    den_s   = (ia_s - ib_s) <<< 1;
    an_s    = $signed({2'b0, sm_r, 1'b0}) - 14'sd5 * (ia_s + ib_s);
    bn_s    = $signed({3'b0, sr_r}) - $signed({3'b0, sl_r});
    den_abs = den_s[13] ? -den_s : den_s;
    an_abs  = an_s[13] ? -an_s : an_s;
    bn_abs  = bn_s[13] ? -bn_s : bn_s;
  end

  always_comb begin
    den_ext = {2'b0, den_mag};
    rs_a    = {rem_a, dvd_a[DW-1]};
    rs_b    = {rem_b, dvd_b[DW-1]};
    ge_a    = (rs_a >= den_ext);
    ge_b    = (rs_b >= den_ext);
    q_a_nx  = DW'({q_a, ge_a});
    q_b_nx  = DW'({q_b, ge_b});
    last    = (fsm == DIV) && (cnt == '0);
  end

  // Outputs are registered on the final DIV edge so they are stable throughout DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_r      <= '0;
      sl_r      <= '0;
      sm_r      <= '0;
      sr_r      <= '0;
      ia_r      <= '0;
      ib_r      <= '0;
      den_mag   <= '0;
      dvd_a     <= '0;
      dvd_b     <= '0;
      q_a       <= '0;
      q_b       <= '0;
      rem_a     <= '0;
      rem_b     <= '0;
      sgn_a     <= 1'b0;
      sgn_b     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      off_a     <= '0;
      slope_b   <= '0;
      edge_ok   <= 1'b0;
      vert      <= 1'b0;
    end else begin
      out_valid <= last;
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st_r <= state;
            sl_r <= sl;
            sm_r <= sm;
            sr_r <= sr;
            ia_r <= int_a;
            ib_r <= int_b;
          end
        end
        PREP: begin
          den_mag <= 9'(den_abs);
          dvd_a   <= DW'(an_abs) << FRAC;
          dvd_b   <= DW'(bn_abs) << FRAC;
          sgn_a   <= an_s[13] ^ den_s[13];
          sgn_b   <= bn_s[13] ^ den_s[13] ^ neg_dir;
          rem_a   <= '0;
          rem_b   <= '0;
          q_a     <= '0;
          q_b     <= '0;
          cnt     <= CW'(DW - 1);
        end
        DIV: begin
          rem_a <= RW'(ge_a ? rs_a - den_ext : rs_a);
          rem_b <= RW'(ge_b ? rs_b - den_ext : rs_b);
          dvd_a <= dvd_a << 1;
          dvd_b <= dvd_b << 1;
          q_a   <= q_a_nx;
          q_b   <= q_b_nx;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            vert <= vert_dir;
            if (den_mag == '0) begin
              off_a   <= '0;
              slope_b <= '0;
              edge_ok <= 1'b0;
            end else begin
              off_a   <= sat(q_a_nx, sgn_a);
              slope_b <= sat(q_b_nx, sgn_b);
              edge_ok <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_param_div.sv
// tb/tb_edge_param_div.sv - self-checking bench for edge_param_div
module tb_edge_param_div;

  localparam int FRAC = 8;
  localparam int OW   = 12;
  localparam int LAT  = 14 + FRAC;
  localparam int PER  = 15 + FRAC;
  localparam int SATV = (1 << (OW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] state = '0;
  logic [10:0] sl = '0, sm = '0, sr = '0;
  logic [7:0] int_a = '0, int_b = '0;
  logic out_valid;
  logic signed [OW-1:0] off_a, slope_b;
  logic edge_ok, vert;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int st, sl, sm, sr, ia, ib;
    int ea, eb, eok, ev;
  } vec_t;

  vec_t vecs[11];
  vec_t hq[$];

  edge_param_div #(.FRAC(FRAC), .OW(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .state(state), .sl(sl), .sm(sm), .sr(sr), .int_a(int_a), .int_b(int_b),
    .out_valid(out_valid), .off_a(off_a), .slope_b(slope_b),
    .edge_ok(edge_ok), .vert(vert)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int clampv(input int x);
    if (x > SATV) return SATV;
    if (x < -SATV) return -SATV;
    return x;
  endfunction

  // Reference: plain signed integer division (truncates toward zero), then clamp and direction fix.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int den, an, bn;
    den = 2 * (v.ia - v.ib);
    an  = 2 * v.sm - 5 * (v.ia + v.ib);
    bn  = v.sr - v.sl;
    r.ev = (v.st == 4 || v.st == 8) ? 1 : 0;
    if (den == 0) begin
      r.ea = 0; r.eb = 0; r.eok = 0;
    end else begin
      r.ea  = clampv((an * (1 << FRAC)) / den);
      r.eb  = clampv((bn * (1 << FRAC)) / den);
      if (v.st == 1 || v.st == 4) r.eb = -r.eb;
      r.eok = 1;
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.st = $urandom_range(15, 0);
    v.sl = $urandom_range(1275, 0);
    v.sm = $urandom_range(1275, 0);
    v.sr = $urandom_range(1275, 0);
    v.ia = $urandom_range(255, 0);
    v.ib = ($urandom_range(7, 0) == 0) ? v.ia : $urandom_range(255, 0);
    return model(v);
  endfunction

  task automatic drive(input vec_t v);
    state = 4'(v.st); sl = 11'(v.sl); sm = 11'(v.sm); sr = 11'(v.sr);
    int_a = 8'(v.ia); int_b = 8'(v.ib);
  endtask

  task automatic run_sample(input string tag, input vec_t v);
    int n, lat;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check({tag, " ready_timeout"}, 0, 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end while (!out_valid && lat < 60);
    check({tag, " latency"}, lat, LAT);
    check({tag, " off_a"}, off_a, v.ea);
    check({tag, " slope_b"}, slope_b, v.eb);
    check({tag, " edge_ok"}, edge_ok, v.eok);
    check({tag, " vert"}, vert, v.ev);
    @(negedge clk);
    check({tag, " out_valid_single"}, out_valid, 0);
  endtask

  initial begin
    int last_acc, ov_seen;
    vec_t v;

    vecs[0]  = '{2, 1000, 600, 200, 200, 40,    0, -640, 1, 0};
    vecs[1]  = '{1, 1000, 600, 200, 200, 40,    0,  640, 1, 0};
    vecs[2]  = '{4, 1000, 600, 200, 200, 40,    0,  640, 1, 1};
    vecs[3]  = '{2,  300, 700, 900, 100, 100,   0,    0, 0, 0};
    vecs[4]  = '{8,    0, 1275, 1275, 101, 100, 2047, 2047, 1, 1};
    vecs[5]  = '{8, 1275, 1275,   0, 101, 100, 2047, -2047, 1, 1};
    vecs[6]  = '{2,    0, 500,   1, 100, 97,  640,   42, 1, 0};
    vecs[7]  = '{2,    1, 500,   0, 100, 97,  640,  -42, 1, 0};
    vecs[8]  = '{3, 1000, 600, 200, 200, 40,    0, -640, 1, 0};
    vecs[9]  = '{2, 1000, 600, 200,  40, 200,   0,  640, 1, 0};
    vecs[10] = '{2,    0,   0,   0,  10, 0,  -640,    0, 1, 0};

    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset off_a", off_a, 0);
    check("reset slope_b", slope_b, 0);
    check("reset edge_ok", edge_ok, 0);
    check("reset vert", vert, 0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++)
      run_sample($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 20; i++)
      run_sample($sformatf("rnd%0d", i), rand_vec());

    // Reset in the middle of the DIV phase must discard the result.
    @(negedge clk);
    drive(vecs[4]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst in_ready_during", in_ready, 1);
    rst = 1'b1;
    ov_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("midrst no_out_valid", ov_seen, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst off_a", off_a, 0);
    check("midrst slope_b", slope_b, 0);
    check("midrst edge_ok", edge_ok, 0);
    check("midrst vert", vert, 0);

    // in_valid held high with data changing every cycle.
    last_acc = -1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (hq.size() == 0) check("hs spurious_out_valid", 1, 0);
        else begin
          v = hq.pop_front();
          check("hs off_a", off_a, v.ea);
          check("hs slope_b", slope_b, v.eb);
          check("hs edge_ok", edge_ok, v.eok);
          check("hs vert", vert, v.ev);
        end
      end
      if (c < 90) begin
        v = rand_vec();
        drive(v);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      if (in_valid && in_ready) begin
        hq.push_back(v);
        if (last_acc >= 0) check("hs spacing", c - last_acc, PER);
        last_acc = c;
      end
    end
    check("hs drained", hq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
